// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: result select, load
// funct3 encodings and the MEM/WB pipeline register layout.
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // wb_sel is kept raw so the reserved encoding 3 can be stored and decoded as ALU.
  typedef struct packed {
    logic        valid;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [2:0]  ld_funct3;
    logic [1:0]  addr_lo;
  } mem_wb_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
    return {{24{is_signed & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
    return {{16{is_signed & h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of the MEM-stage inputs, the multi-cycle unit handshake and the
// register file write port. master = upstream/environment, slave = the stage.
interface writeback_stage_if #(
  parameter int CNT_W = 64
);
  logic              flush;
  logic              in_valid;
  logic              in_rd_we;
  logic [4:0]        in_rd_idx;
  logic [1:0]        in_wb_sel;
  logic [31:0]       in_alu_result;
  logic [31:0]       in_mem_rdata;
  logic [31:0]       in_pc_plus4;
  logic [2:0]        in_ld_funct3;
  logic [1:0]        in_addr_lo;

  // mc handshake: a transfer happens on a posedge where mc_valid & mc_ready;
  // the unit holds mc_valid/mc_rd_idx/mc_data stable until that edge.
  logic              mc_valid;
  logic [4:0]        mc_rd_idx;
  logic [31:0]       mc_data;
  logic              mc_ready;

  logic              hold_req;
  logic              wr_en;
  logic [4:0]        wr_idx;
  logic [31:0]       wr_data;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output flush, in_valid, in_rd_we, in_rd_idx, in_wb_sel, in_alu_result,
           in_mem_rdata, in_pc_plus4, in_ld_funct3, in_addr_lo,
           mc_valid, mc_rd_idx, mc_data,
    input  mc_ready, hold_req, wr_en, wr_idx, wr_data, retire_count
  );

  modport slave (
    input  flush, in_valid, in_rd_we, in_rd_idx, in_wb_sel, in_alu_result,
           in_mem_rdata, in_pc_plus4, in_ld_funct3, in_addr_lo,
           mc_valid, mc_rd_idx, mc_data,
    output mc_ready, hold_req, wr_en, wr_idx, wr_data, retire_count
  );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Extracts the addressed byte/halfword lane from an aligned load word and
// sign- or zero-extends it; words and unknown funct3 pass through untouched.
module load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_result = i_rdata;
    case (i_funct3)
      F3_LB:   o_result = ext_byte(w_byte, 1'b1);
      F3_LBU:  o_result = ext_byte(w_byte, 1'b0);
      F3_LH:   o_result = ext_half(w_half, 1'b1);
      F3_LHU:  o_result = ext_half(w_half, 1'b0);
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, result select, register file write
// port shared with a multi-cycle unit, starvation hold and retire counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int MC_MAX_WAIT = 4,
  parameter int CNT_W       = 64
) (
  input logic               clk,
  input logic               resetn,
  writeback_stage_if.slave  bus
);

  localparam int WAIT_W = $clog2(MC_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MC_MAX_WAIT);

  mem_wb_t             r_wb;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_retire_count;

  logic [31:0]         w_load_data;
  logic [31:0]         w_result;
  logic                w_pipe_req;
  logic                w_mc_ready;
  logic                w_transfer;

  load_formatter u_load_formatter (
    .i_funct3  (r_wb.ld_funct3),
    .i_addr_lo (r_wb.addr_lo),
    .i_rdata   (r_wb.mem_rdata),
    .o_result  (w_load_data)
  );

  always_comb begin
    case (r_wb.wb_sel)
      WB_MEM:  w_result = w_load_data;
      WB_PC4:  w_result = r_wb.pc_plus4;
      default: w_result = r_wb.alu_result;
    endcase
  end

  assign w_pipe_req = r_wb.valid & r_wb.rd_we & (r_wb.rd_idx != 5'd0);
  // Pipeline always wins the port; gating with resetn keeps it silent in reset.
  assign w_mc_ready = ~w_pipe_req & resetn;
  assign w_transfer = bus.mc_valid & w_mc_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb           <= '0;
      r_wait_cnt     <= '0;
      r_retire_count <= '0;
    end else begin
      r_wb.valid <= bus.in_valid & ~bus.flush;
      if (bus.in_valid) begin
        r_wb.rd_we      <= bus.in_rd_we;
        r_wb.rd_idx     <= bus.in_rd_idx;
        r_wb.wb_sel     <= bus.in_wb_sel;
        r_wb.alu_result <= bus.in_alu_result;
        r_wb.mem_rdata  <= bus.in_mem_rdata;
        r_wb.pc_plus4   <= bus.in_pc_plus4;
        r_wb.ld_funct3  <= bus.in_ld_funct3;
        r_wb.addr_lo    <= bus.in_addr_lo;
      end
      if (r_wb.valid) begin
        r_retire_count <= r_retire_count + CNT_W'(1);
      end
      // Counts consecutive refused cycles of one pending mc result.
      if (!bus.mc_valid || w_transfer) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_idx  = 5'd0;
    bus.wr_data = 32'd0;
    if (resetn) begin
      if (w_pipe_req) begin
        bus.wr_en   = 1'b1;
        bus.wr_idx  = r_wb.rd_idx;
        bus.wr_data = w_result;
      end else if (bus.mc_valid && (bus.mc_rd_idx != 5'd0)) begin
        bus.wr_en   = 1'b1;
        bus.wr_idx  = bus.mc_rd_idx;
        bus.wr_data = bus.mc_data;
      end
    end
  end

  assign bus.mc_ready     = w_mc_ready;
  assign bus.hold_req     = resetn & bus.mc_valid & ~w_mc_ready & (r_wait_cnt == WAIT_MAX);
  assign bus.retire_count = r_retire_count;

endmodule
